char_stream_arbiter: RTL

Word-granular round-robin arbiter that shares one downstream ASCII character checker (begin/end block matcher) between two character sources. A grant is held for a whole word, so characters from different sources are never interleaved inside a word. The grant is released on the delimiter, on a maximum-length limit, or on an idle timeout. The block sits between the two stream producers and the checker's `in` port, presenting one registered character stream with source tagging.

---
 rtl/char_stream_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/char_stream_arbiter.sv
// Word-granular two-source round-robin arbiter feeding one registered character stream.
// Optional build macro CSA_CASEFOLD_EN: fold accepted 'A'-'Z' to lower case on the way out.
module char_stream_arbiter #(
  parameter int          MAX_WORD = 16,
  parameter int          IDLE_MAX = 8,
  parameter logic [7:0]  DELIM    = 8'd32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       out_src,
  output logic       out_last,
  input  logic       out_ready,
  output logic       forced,
  output logic       abort
);

  localparam int CW = $clog2(MAX_WORD + 1);
  localparam int IW = $clog2(IDLE_MAX + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_WORD);
  localparam logic [IW-1:0] IDLE_C = IW'(IDLE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1} state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_char_q, out_char_d;
  logic          out_src_q, out_src_d;
  logic          out_last_q, out_last_d;
  logic          forced_q, forced_d;
  logic          abort_q, abort_d;

  logic          g_src, g_valid, accept;
  logic [7:0]    g_char;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CSA_CASEFOLD_EN
    return (c >= 8'd65 && c <= 8'd90) ? c + 8'd32 : c;
`else
    return c;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      idle_q      <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'd0;
      out_src_q   <= 1'b0;
      out_last_q  <= 1'b0;
      forced_q    <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      forced_q    <= forced_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    g_src       = (state_q == S_GRANT1);
    g_valid     = g_src ? req1_valid : req0_valid;
    g_char      = g_src ? req1_char : req0_char;
    accept      = (req0_ready || req1_ready) && g_valid;
    cnt_inc     = cnt_q + CW'(1);
    idle_inc    = idle_q + IW'(1);
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    forced_d    = 1'b0;
    abort_d     = 1'b0;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (req0_valid && req1_valid) state_d = rr_q ? S_GRANT1 : S_GRANT0;
        else if (req0_valid)          state_d = S_GRANT0;
        else if (req1_valid)          state_d = S_GRANT1;
      end
      default: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_char_d  = fold(g_char);
          out_src_d   = g_src;
          idle_d      = '0;
          if (g_char == DELIM || cnt_inc == MAX_C) begin
            out_last_d = 1'b1;
            forced_d   = (g_char != DELIM);
            state_d    = S_IDLE;
            rr_d       = ~g_src;
            cnt_d      = '0;
          end else begin
            out_last_d = 1'b0;
            cnt_d      = cnt_inc;
          end
        end else if (!g_valid) begin
          // word lock: a silent granted source keeps the grant until the timeout
          if (idle_inc == IDLE_C) begin
            abort_d = 1'b1;
            state_d = S_IDLE;
            rr_d    = ~g_src;
            cnt_d   = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_inc;
          end
        end else begin
          idle_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    req0_ready = (state_q == S_GRANT0) && (!out_valid_q || out_ready);
    req1_ready = (state_q == S_GRANT1) && (!out_valid_q || out_ready);
    out_valid  = out_valid_q;
    out_char   = out_char_q;
    out_src    = out_src_q;
    out_last   = out_last_q;
    forced     = forced_q;
    abort      = abort_q;
  end

endmodule
